// File: rtl/dmem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_if : load/store handshake between the memory stage and dmem_responder |
// | Optional err signal present when DMEM_ALIGN_CHECK_EN is defined.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dmem_if #(
   parameter int ADDR_W = 14
);
   logic              req;
   logic              mem_read;
   logic              mem_write;
   logic [3:0]        store_op;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ack;
   logic              busy;
`ifdef DMEM_ALIGN_CHECK_EN
   logic              err;

   modport master (
      output req, mem_read, mem_write, store_op, mem_addr, wdata,
      input  rdata, ack, busy, err
   );
   modport slave (
      input  req, mem_read, mem_write, store_op, mem_addr, wdata,
      output rdata, ack, busy, err
   );
`else
   modport master (
      output req, mem_read, mem_write, store_op, mem_addr, wdata,
      input  rdata, ack, busy
   );
   modport slave (
      input  req, mem_read, mem_write, store_op, mem_addr, wdata,
      output rdata, ack, busy
   );
`endif
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder : data-memory target with word RAM, wait states, 1-cyc ack  |
// | Optional alignment checking enabled by macro DMEM_ALIGN_CHECK_EN.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_responder #(
   parameter int ADDR_W      = 14,
   parameter int WAIT_CYCLES = 1
) (
   input  wire logic clk,
   input  wire logic rst,
   dmem_if.slave     bus
);
   localparam int         c_DEPTH   = 2 ** (ADDR_W - 2);
   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_WAIT    = 2'd1;
   localparam logic [1:0] c_RESP    = 2'd2;
   localparam logic [3:0] c_WAIT_LD = 4'(WAIT_CYCLES);

   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [3:0]        r_cnt;
   logic [ADDR_W-3:0] r_word;
   logic [3:0]        r_store_op;
   logic [31:0]       r_wdata;
   logic              r_is_wr;
   logic              r_is_rd;
   logic [31:0]       r_rdata;
   logic [31:0]       r_mem [c_DEPTH];

   logic              w_accept;
   logic              w_in_idle;
   logic [ADDR_W-3:0] w_sel_word;
   logic              w_sel_rd;
   logic              w_sel_ok;
   logic              w_cur_ok;

   assign w_in_idle = (r_state == c_IDLE);
   assign w_accept  = w_in_idle && bus.req && (bus.mem_read || bus.mem_write);

   // The read is launched on the edge entering RESP so rdata is valid alongside ack;
   // with zero wait states that edge is the accept edge, hence the bypass of the captured regs.
   assign w_sel_word = w_in_idle ? bus.mem_addr[ADDR_W-1:2] : r_word;
   assign w_sel_rd   = w_in_idle ? (bus.mem_read && !bus.mem_write) : r_is_rd;

`ifdef DMEM_ALIGN_CHECK_EN
   logic r_ok;

   function automatic logic f_legal(input logic [3:0] m, input logic [1:0] a);
      case (m)
         4'b0001: f_legal = (a == 2'd0);
         4'b0010: f_legal = (a == 2'd1);
         4'b0100: f_legal = (a == 2'd2);
         4'b1000: f_legal = (a == 2'd3);
         4'b0011: f_legal = (a == 2'd0);
         4'b1100: f_legal = (a == 2'd2);
         4'b1111: f_legal = (a == 2'd0);
         default: f_legal = 1'b0;
      endcase
   endfunction

   assign w_sel_ok = w_in_idle ? f_legal(bus.store_op, bus.mem_addr[1:0]) : r_ok;
   assign w_cur_ok = r_ok;

   always_ff @(posedge clk) begin
      if (rst)
         r_ok <= 1'b1;
      else if (w_accept)
         r_ok <= f_legal(bus.store_op, bus.mem_addr[1:0]);
   end
`else
   logic w_unused;
   assign w_unused = ^bus.mem_addr[1:0];
   assign w_sel_ok = 1'b1;
   assign w_cur_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_accept)
            r_cnt <= c_WAIT_LD;
         else if (r_state == c_WAIT)
            r_cnt <= r_cnt - 4'd1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_next = (c_WAIT_LD == 4'd0) ? c_RESP : c_WAIT;
         c_WAIT:  if (r_cnt == 4'd1) w_next = c_RESP;
         c_RESP:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   always_comb begin
      bus.ack  = (r_state == c_RESP);
      bus.busy = (r_state != c_IDLE);
`ifdef DMEM_ALIGN_CHECK_EN
      bus.err  = (r_state == c_RESP) && !r_ok;
`endif
   end

   assign bus.rdata = r_rdata;

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_word     <= bus.mem_addr[ADDR_W-1:2];
         r_store_op <= bus.store_op;
         r_wdata    <= bus.wdata;
         r_is_wr    <= bus.mem_write;
         r_is_rd    <= bus.mem_read && !bus.mem_write;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_rdata <= 32'd0;
      else if (w_next == c_RESP && w_sel_rd)
         r_rdata <= w_sel_ok ? r_mem[w_sel_word] : 32'd0;
   end

   // Commit stores on the edge leaving RESP so a reset inside the access drops the write.
   always_ff @(posedge clk) begin
      if (!rst && r_state == c_RESP && r_is_wr && w_cur_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (r_store_op[i])
               r_mem[r_word][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end
endmodule
`default_nettype wire
